// File: rtl/q_column3_norm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : q_column3_norm_pkg
// Brief    : Shared constants and helpers for the column-3 normalisation stage
// Revision : 1.0 - initial release
// ============================================================================
package q_column3_norm_pkg;

    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_ACCUM = 3'd1;
    localparam logic [2:0] C_ST_SQRT  = 3'd2;
    localparam logic [2:0] C_ST_RECIP = 3'd3;
    localparam logic [2:0] C_ST_SCALE = 3'd4;
    localparam logic [2:0] C_ST_READY = 3'd5;

    localparam logic [4:0] C_ACCUM_LEN = 5'd8;
    localparam logic [4:0] C_SQRT_LEN  = 5'd18;
    localparam logic [4:0] C_RECIP_LEN = 5'd16;
    localparam logic [4:0] C_SCALE_LEN = 5'd8;

    localparam int C_PART_W    = 16;
    localparam int C_FRAC_W    = 12;
    localparam int C_ACC_W     = 36;
    localparam int C_ROOT_W    = 18;
    localparam int C_NUM_PARTS = 8;

    localparam logic [15:0] C_SAT_POS        = 16'h7FFF;
    localparam logic [15:0] C_SAT_NEG        = 16'h8000;
    localparam logic [15:0] C_RECIP_MAX      = 16'hFFFF;
    localparam logic [15:0] C_RECIP_MIN_NORM = 16'h0100;
    // 2^24 >> 16: dividend bits above the 16 quotient positions
    localparam logic [15:0] C_RECIP_SEED     = 16'h0100;

    function automatic logic [15:0] sat_q412(input logic signed [32:0] prod);
        logic signed [32:0] shifted;
        shifted = prod >>> C_FRAC_W;
        if (shifted > 33'sd32767)
            return C_SAT_POS;
        else if (shifted < -33'sd32768)
            return C_SAT_NEG;
        else
            return shifted[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/isqrt_seq.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_seq
// Brief    : Bit-serial restoring square root, 36-bit radicand to 18-bit root
// Revision : 1.0 - initial release
// ============================================================================
module isqrt_seq
    import q_column3_norm_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [C_ACC_W-1:0]    radicand,
    output logic                  done,
    output logic [C_ROOT_W-1:0]   root
);

    logic [C_ACC_W-1:0]  r_x;
    logic [19:0]         r_rem;
    logic [C_ROOT_W-1:0] r_root;
    logic [4:0]          r_cnt;
    logic                r_busy;

    logic [C_ACC_W-1:0]  w_x_src;
    logic [19:0]         w_rem_src;
    logic [C_ROOT_W-1:0] w_root_src;
    logic [19:0]         w_rem_sh;
    logic [19:0]         w_trial;
    logic                w_ge;

    // The start cycle already performs the first iteration on the fresh operand.
    assign w_x_src    = start ? radicand : r_x;
    assign w_rem_src  = start ? 20'd0 : r_rem;
    assign w_root_src = start ? '0 : r_root;
    assign w_rem_sh   = (w_rem_src << 2) | {18'd0, w_x_src[C_ACC_W-1 -: 2]};
    assign w_trial    = {w_root_src, 2'b01};
    assign w_ge       = (w_rem_sh >= w_trial);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x    <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start || r_busy) begin
            r_x    <= w_x_src << 2;
            r_rem  <= w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
            r_root <= (w_root_src << 1) | {{(C_ROOT_W-1){1'b0}}, w_ge};
            r_cnt  <= start ? 5'd1 : (r_cnt + 5'd1);
            r_busy <= start || (r_cnt != (C_SQRT_LEN - 5'd1));
        end
    end

    // done flags the final iteration; root is valid from the following cycle.
    assign done = r_busy && (r_cnt == (C_SQRT_LEN - 5'd1));
    assign root = r_root;

endmodule
`default_nettype wire

// File: rtl/q_column3_norm.sv
`default_nettype none
// ============================================================================
// Module   : q_column3_norm
// Brief    : Normalises the third Q column: r33 = ||col||, Q_col3 = col / r33
// Revision : 1.0 - initial release
// ============================================================================
module q_column3_norm
    import q_column3_norm_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         accept_in,
    output logic         accept_out,
    output logic         ready_out,
    input  logic [127:0] Q_col3_pre,
    output logic [127:0] Q_col3,
    output logic [15:0]  r33,
    output logic         zero_norm
);

    // ---------------- controller ----------------
    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [4:0] r_cnt;

    logic w_capture;
    logic w_acc_en;
    logic w_sqrt_start;
    logic w_sqrt_done;
    logic w_div_en;
    logic w_scale_en;
    logic w_load_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= C_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state || r_state == C_ST_IDLE || r_state == C_ST_READY)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 5'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_IDLE:  if (enable)                           w_state_next = C_ST_ACCUM;
            C_ST_ACCUM: if (r_cnt == C_ACCUM_LEN - 5'd1)      w_state_next = C_ST_SQRT;
            C_ST_SQRT:  if (w_sqrt_done)                      w_state_next = C_ST_RECIP;
            C_ST_RECIP: if (r_cnt == C_RECIP_LEN - 5'd1)      w_state_next = C_ST_SCALE;
            // One drain cycle after the last write so the output load sees it.
            C_ST_SCALE: if (r_cnt == C_SCALE_LEN)             w_state_next = C_ST_READY;
            C_ST_READY: if (accept_in)                        w_state_next = C_ST_IDLE;
            default:                                          w_state_next = C_ST_IDLE;
        endcase
    end

    always_comb begin
        accept_out   = (r_state == C_ST_IDLE);
        w_capture    = (r_state == C_ST_IDLE) && enable;
        w_acc_en     = (r_state == C_ST_ACCUM);
        w_sqrt_start = (r_state == C_ST_SQRT) && (r_cnt == 5'd0);
        w_div_en     = (r_state == C_ST_RECIP);
        w_scale_en   = (r_state == C_ST_SCALE) && (r_cnt < C_SCALE_LEN);
        w_load_out   = (r_state == C_ST_SCALE) && (r_cnt == C_SCALE_LEN);
    end

    // ---------------- datapath ----------------
    logic [C_PART_W-1:0] r_buf [C_NUM_PARTS];
    logic [C_ACC_W-1:0]  r_acc;
    logic [16:0]         r_rem;
    logic [15:0]         r_quot;
    logic [127:0]        r_q_col3;
    logic [15:0]         r_r33;
    logic                r_zero_norm;
    logic                r_ready_out;

    logic [C_ROOT_W-1:0] w_root;
    logic [15:0]         w_norm;
    logic [15:0]         w_recip;
    logic [C_PART_W-1:0] w_part;
    logic [32:0]         w_part_ext;
    logic [31:0]         w_sq;
    logic signed [32:0]  w_prod;
    logic [16:0]         w_div_rem_src;
    logic [15:0]         w_div_quot_src;
    logic [16:0]         w_div_shift;
    logic                w_div_ge;
    logic [16:0]         w_div_rem_next;
    logic [15:0]         w_div_quot_next;

    isqrt_seq u_isqrt (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (w_sqrt_start),
        .radicand (r_acc),
        .done     (w_sqrt_done),
        .root     (w_root)
    );

    assign w_norm = (w_root > 18'h07FFF) ? C_SAT_POS : w_root[15:0];

    // Shared multiplier: squares during ACCUM, scales by the reciprocal during SCALE.
    assign w_part     = r_buf[r_cnt[2:0]];
    assign w_part_ext = {{17{w_part[C_PART_W-1]}}, w_part};
    assign w_sq       = w_part_ext[31:0] * w_part_ext[31:0];
    assign w_prod     = $signed(w_part_ext * {17'd0, w_recip});

    assign w_div_rem_src   = (r_cnt == 5'd0) ? {1'b0, C_RECIP_SEED} : r_rem;
    assign w_div_quot_src  = (r_cnt == 5'd0) ? 16'd0 : r_quot;
    assign w_div_shift     = w_div_rem_src << 1;
    assign w_div_ge        = (w_div_shift >= {1'b0, w_norm});
    assign w_div_rem_next  = w_div_ge ? (w_div_shift - {1'b0, w_norm}) : w_div_shift;
    assign w_div_quot_next = (w_div_quot_src << 1) | {15'd0, w_div_ge};

    assign w_recip = (w_norm == 16'd0)              ? 16'd0 :
                     (w_norm <= C_RECIP_MIN_NORM)   ? C_RECIP_MAX :
                                                      r_quot;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < C_NUM_PARTS; p++)
                r_buf[p] <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_q_col3    <= '0;
            r_r33       <= '0;
            r_zero_norm <= 1'b0;
            r_ready_out <= 1'b0;
        end else begin
            r_ready_out <= (r_state == C_ST_READY);
            if (w_capture) begin
                for (int p = 0; p < C_NUM_PARTS; p++)
                    r_buf[p] <= Q_col3_pre[16*p +: 16];
                r_acc <= '0;
            end
            if (w_acc_en)
                r_acc <= r_acc + {4'd0, w_sq};
            if (w_div_en) begin
                r_rem  <= w_div_rem_next;
                r_quot <= w_div_quot_next;
            end
            if (w_scale_en)
                r_buf[r_cnt[2:0]] <= sat_q412(w_prod);
            if (w_load_out) begin
                for (int p = 0; p < C_NUM_PARTS; p++)
                    r_q_col3[16*p +: 16] <= r_buf[p];
                r_r33       <= w_norm;
                r_zero_norm <= (r_acc == '0);
            end
        end
    end

    assign Q_col3    = r_q_col3;
    assign r33       = r_r33;
    assign zero_norm = r_zero_norm;
    assign ready_out = r_ready_out;

endmodule
`default_nettype wire

// File: tb/tb_q_column3_norm.sv
`default_nettype none
// ============================================================================
// Module   : tb_q_column3_norm
// Brief    : Self-checking bench for q_column3_norm with a reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_q_column3_norm;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         accept_in;
    logic         accept_out;
    logic         ready_out;
    logic [127:0] Q_col3_pre;
    logic [127:0] Q_col3;
    logic [15:0]  r33;
    logic         zero_norm;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] d_pre [5];
    logic [127:0] d_q   [5];
    logic [15:0]  d_r   [5];

    always #5 clk = ~clk;

    q_column3_norm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .accept_in  (accept_in),
        .accept_out (accept_out),
        .ready_out  (ready_out),
        .Q_col3_pre (Q_col3_pre),
        .Q_col3     (Q_col3),
        .r33        (r33),
        .zero_norm  (zero_norm)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Norm by greedy bit search, reciprocal by integer division, floor-shift scaling.
    function automatic void model(input logic [127:0] pre, output logic [127:0] q,
                                  output logic [15:0] r, output logic z);
        longint sum, rt, t, norm, recip, v, prod, fl;
        sum = 0;
        for (int p = 0; p < 8; p++) begin
            v = longint'($signed(pre[16*p +: 16]));
            sum += v * v;
        end
        z  = (sum == 0);
        rt = 0;
        for (int b = 17; b >= 0; b--) begin
            t = rt | (longint'(1) << b);
            if (t * t <= sum) rt = t;
        end
        norm = (rt > 32767) ? 32767 : rt;
        if (norm == 0)        recip = 0;
        else if (norm <= 256) recip = 65535;
        else                  recip = (longint'(1) << 24) / norm;
        q = '0;
        for (int p = 0; p < 8; p++) begin
            v    = longint'($signed(pre[16*p +: 16]));
            prod = v * recip;
            fl   = prod / 4096;
            if (prod < 0 && (prod % 4096) != 0) fl = fl - 1;
            if (fl > 32767)  fl = 32767;
            if (fl < -32768) fl = -32768;
            q[16*p +: 16] = fl[15:0];
        end
        r = norm[15:0];
    endfunction

    task automatic run_job(input string tag, input logic [127:0] pre, input logic [127:0] eq,
                           input logic [15:0] er, input logic ez, input int hold);
        int lat;
        Q_col3_pre = pre;
        enable     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable     = 1'b0;
        Q_col3_pre = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!ready_out && lat < 200) begin
            if (lat < 45) begin
                enable    = 1'($urandom % 2);
                accept_in = 1'($urandom % 2);
            end else begin
                enable    = 1'b0;
                accept_in = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        enable    = 1'b0;
        accept_in = 1'b0;
        check({tag, "/latency"}, lat, 52);
        check({tag, "/r33"}, r33, er);
        check({tag, "/q_col3"}, Q_col3, eq);
        check({tag, "/zero_norm"}, zero_norm, ez);
        check({tag, "/accept_out_busy"}, accept_out, 1'b0);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                @(negedge clk);
            end
            check({tag, "/hold_ready"}, ready_out, 1'b1);
            check({tag, "/hold_q"}, Q_col3, eq);
            check({tag, "/hold_r33"}, r33, er);
        end
        accept_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        accept_in = 1'b0;
        check({tag, "/accept_out_idle"}, accept_out, 1'b1);
        check({tag, "/ready_lag"}, ready_out, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check({tag, "/ready_fall"}, ready_out, 1'b0);
        check({tag, "/idle_q_held"}, Q_col3, eq);
    endtask

    initial begin
        logic [127:0] pre, eq;
        logic [15:0]  er;
        logic         ez;
        logic signed [15:0] sv;

        reset_n    = 1'b0;
        enable     = 1'b0;
        accept_in  = 1'b0;
        Q_col3_pre = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/q_col3", Q_col3, 128'd0);
        check("reset/r33", r33, 16'd0);
        check("reset/zero_norm", zero_norm, 1'b0);
        check("reset/ready_out", ready_out, 1'b0);
        check("reset/accept_out", accept_out, 1'b1);
        reset_n = 1'b1;

        d_pre[0] = 128'h1000_0000;           d_q[0] = 128'h1000_0000;           d_r[0] = 16'h1000;
        d_pre[1] = 128'h3000_4000;           d_q[1] = 128'h0999_0CCC;           d_r[1] = 16'h5000;
        d_pre[2] = {4{32'h0800_0000}};       d_q[2] = {4{32'h0800_0000}};       d_r[2] = 16'h1000;
        d_pre[3] = 128'hD000_0000;           d_q[3] = 128'hF001_0000;           d_r[3] = 16'h3000;
        d_pre[4] = 128'd0;                   d_q[4] = 128'd0;                   d_r[4] = 16'h0000;

        for (int i = 0; i < 5; i++)
            run_job($sformatf("dir%0d", i), d_pre[i], d_q[i], d_r[i], (i == 4), (i == 0) ? 10 : 0);

        for (int j = 0; j < 24; j++) begin
            pre = '0;
            for (int p = 0; p < 8; p++) begin
                sv = 16'($urandom);
                sv = sv >>> $urandom_range(0, 15);
                if ($urandom % 4 == 0) sv = 16'sd0;
                pre[16*p +: 16] = sv;
            end
            model(pre, eq, er, ez);
            run_job($sformatf("rnd%0d", j), pre, eq, er, ez, 0);
        end

        // Abort during SQRT: outputs hold a prior nonzero result beforehand.
        run_job("pre_abort", d_pre[0], d_q[0], d_r[0], 1'b0, 0);
        Q_col3_pre = d_pre[1];
        enable     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort/q_col3", Q_col3, 128'd0);
        check("abort/r33", r33, 16'd0);
        check("abort/ready_out", ready_out, 1'b0);
        check("abort/accept_out", accept_out, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        run_job("post_abort", d_pre[1], d_q[1], d_r[1], 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
